// File: rtl/support_io_arbiter.sv
// support_io_arbiter: two-master round-robin arbiter onto the 16-device support IO Wishbone bus.
// Latency: device strobe 1 cycle after request; master ack 1 cycle after device ack; 1 RELEASE cycle after.
// Backpressure: losing master holds its strobe until granted; a silent device is cut off after TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   m0_* / m1_*               master side: per-device stb/we, adr, write dat in; ack/err pulse and read dat out
//   s_stb_o/s_we_o            one-hot device strobe and write enable
//   s_adr_o/s_dat_o           address and write data latched at grant
//   s_ack_i/s_dat_i           per-device ack and merged read data (device n at [8n+7:8n])
//   busy_o/owner_o            cycle in progress, current or most recent grantee
module support_io_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [15:0]   m0_stb_i,
   input  logic [15:0]   m0_we_i,
   input  logic [7:0]    m0_adr_i,
   input  logic [7:0]    m0_dat_i,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   output logic [7:0]    m0_dat_o,
   input  logic [15:0]   m1_stb_i,
   input  logic [15:0]   m1_we_i,
   input  logic [7:0]    m1_adr_i,
   input  logic [7:0]    m1_dat_i,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic [7:0]    m1_dat_o,
   output logic [15:0]   s_stb_o,
   output logic [15:0]   s_we_o,
   output logic [7:0]    s_adr_o,
   output logic [7:0]    s_dat_o,
   input  logic [15:0]   s_ack_i,
   input  logic [127:0]  s_dat_i,
   output logic          busy_o,
   output logic          owner_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // Counter value at which the cycle is forced to end; gives exactly TIMEOUT strobe cycles.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t       state;
   logic         last;
   logic [3:0]   dev;
   logic [15:0]  cnt;

   logic         req0;
   logic         req1;
   logic         gnt1;
   logic [15:0]  g_stb;
   logic [15:0]  g_we;
   logic [7:0]   g_adr;
   logic [7:0]   g_dat;
   logic [3:0]   g_dev;
   logic [15:0]  g_onehot;
   logic         dev_ack;
   logic         done;
   logic [7:0]   rd_dat;

   // Lowest set bit wins when a master strobes more than one device.
   function automatic logic [3:0] low_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   always_comb begin
      req0     = |m0_stb_i;
      req1     = |m1_stb_i;
      // On a tie, the master that was not served last gets the bus.
      gnt1     = req1 && (!req0 || !last);
      g_stb    = gnt1 ? m1_stb_i : m0_stb_i;
      g_we     = gnt1 ? m1_we_i  : m0_we_i;
      g_adr    = gnt1 ? m1_adr_i : m0_adr_i;
      g_dat    = gnt1 ? m1_dat_i : m0_dat_i;
      g_dev    = low_idx(g_stb);
      g_onehot = 16'd1 << g_dev;
      // Only the selected device's ack counts; stray acks are ignored.
      dev_ack  = s_ack_i[dev];
      // A real ack on the timeout edge takes precedence over the timeout.
      done     = dev_ack || (cnt == TO_LAST);
      rd_dat   = dev_ack ? s_dat_i[{dev, 3'b000} +: 8] : 8'hff;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         last     <= 1'b1;
         dev      <= 4'd0;
         cnt      <= 16'd0;
         s_stb_o  <= 16'd0;
         s_we_o   <= 16'd0;
         s_adr_o  <= 8'hff;
         s_dat_o  <= 8'hff;
         m0_ack_o <= 1'b0;
         m0_err_o <= 1'b0;
         m0_dat_o <= 8'hff;
         m1_ack_o <= 1'b0;
         m1_err_o <= 1'b0;
         m1_dat_o <= 8'hff;
         busy_o   <= 1'b0;
         owner_o  <= 1'b0;
      end else begin
         m0_ack_o <= 1'b0;
         m0_err_o <= 1'b0;
         m1_ack_o <= 1'b0;
         m1_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner_o <= gnt1;
                  dev     <= g_dev;
                  s_adr_o <= g_adr;
                  s_dat_o <= g_dat;
                  s_stb_o <= g_onehot;
                  s_we_o  <= g_we[g_dev] ? g_onehot : 16'd0;
                  cnt     <= 16'd0;
                  busy_o  <= 1'b1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (done) begin
                  s_stb_o <= 16'd0;
                  s_we_o  <= 16'd0;
                  last    <= owner_o;
                  state   <= RELEASE;
                  if (owner_o) begin
                     m1_ack_o <= 1'b1;
                     m1_err_o <= !dev_ack;
                     m1_dat_o <= rd_dat;
                  end else begin
                     m0_ack_o <= 1'b1;
                     m0_err_o <= !dev_ack;
                     m0_dat_o <= rd_dat;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RELEASE: begin
               // The owner's strobe may still be high here; it is deliberately not looked at.
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/support_io_arbiter.md
# support_io_arbiter

Two-master Wishbone arbiter for the support IO device bus. It sits between the Z80-side bus bridge (master 0) and the support-processor port (master 1) on one side, and the 16 support devices on the other. It grants the shared device bus to one master at a time using round-robin priority, latches the address, data, device and direction at grant, and waits for that device's ack. It terminates any cycle that exceeds a timeout with an error pulse, so a dead device cannot lock either master.

## Interface
Parameters:
- TIMEOUT, 255: cycles in BUSY without ack before forced termination; legal range 1–65535. The counter is 16 bits.

Ports:
- clk_i  in  1  single clock; everything is sampled on its rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- m0_stb_i  in  16  master 0 per-device strobe; one-hot expected.
- m0_we_i  in  16  master 0 per-device write enable.
- m0_adr_i  in  8  master 0 address.
- m0_dat_i  in  8  master 0 write data.
- m0_ack_o  out  1  one-cycle ack to master 0.
- m0_err_o  out  1  one-cycle timeout flag, coincident with m0_ack_o.
- m0_dat_o  out  8  read data to master 0; holds until the next master 0 completion.
- m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_ack_o, m1_err_o, m1_dat_o: same as master 0, for master 1.
- s_stb_o  out  16  one-hot device strobe.
- s_we_o  out  16  one-hot write enable; a bit is set only together with the matching s_stb_o bit.
- s_adr_o  out  8  latched address.
- s_dat_o  out  8  latched write data.
- s_ack_i  in  16  per-device ack.
- s_dat_i  in  128  merged device read data; device n occupies bits [8n+7:8n].
- busy_o  out  1  high in BUSY and RELEASE.
- owner_o  out  1  current or most recent grantee.

## Operation
- States: IDLE, BUSY, RELEASE.
- Request: master k requests when any bit of mk_stb_i is set. The device index is the lowest set bit; other set bits are ignored.
- IDLE:
  - Only one master requesting: grant it.
  - Both requesting: grant the master not served last.
  - A pointer `last` tracks the master served last; reset sets last=1, so master 0 wins the first tie.
- On grant, register the following, then enter BUSY:
  - device index, mk_adr_i, mk_dat_i, mk_we_i[dev], owner;
  - drive s_stb_o[dev]=1 and s_we_o[dev]=mk_we_i[dev];
  - clear the timeout counter.
- Master inputs that change after grant have no effect on the cycle in progress.
- BUSY, s_ack_i[dev]=1 at an edge (normal completion):
  - clear s_stb_o and s_we_o;
  - latch s_dat_i[8dev+7:8dev] into m{owner}_dat_o;
  - pulse m{owner}_ack_o for one cycle;
  - set last=owner;
  - enter RELEASE.
- BUSY, acks from non-selected devices are ignored.
- BUSY, counter reaches TIMEOUT-1 with no ack (timeout):
  - same as normal completion, except m{owner}_dat_o is set to 8'hff;
  - m{owner}_err_o pulses together with the ack.
  - If the ack and the timeout happen on the same edge, the ack wins and err_o stays 0.
- RELEASE: lasts one cycle; the owner's strobe is ignored during it, covering the master's one-cycle strobe-drop latency; then go to IDLE. A request from the other master seen in RELEASE is not granted until IDLE.
- Writes: read data is still latched into m{owner}_dat_o on completion; masters ignore it.

## Timing
- Reset values:
  - all strobes, write enables, acks and errs 0;
  - s_adr_o=8'hff, s_dat_o=8'hff, m0_dat_o=m1_dat_o=8'hff;
  - busy_o=0, owner_o=0, last=1, state IDLE, counter 0.
- Asserting rst_i in any state aborts the cycle in progress with no ack or err. Outputs reach reset values at the next edge.
- Grant latency: request sampled at edge E; s_stb_o is visible after E, one cycle.
- Completion latency: s_ack_i sampled at edge A; mk_ack_o and mk_dat_o are visible after A, and s_stb_o is low after A.
- Back-to-back: the minimum period per transaction is 3 cycles plus device ack latency. Edges are grant, ack, RELEASE→IDLE, then the next grant.
- Timeout: with no ack, s_stb_o is high for exactly TIMEOUT cycles.

## Test plan
- Single write: m0 asserts stb=16'h0004, we=16'h0004, adr=8'h23, dat=8'h5a; device 2 acks 3 cycles later -> s_stb_o=16'h0004, s_we_o=16'h0004, s_adr_o=8'h23, s_dat_o=8'h5a; one m0_ack_o pulse; m0_err_o=0.
- Read: m1 asserts stb=16'h8000, we=0; s_dat_i[127:120]=8'hc3 with ack -> m1_dat_o=8'hc3, m1_ack_o pulses once, and s_we_o stays 0 throughout.
- Contention: both masters request on the same cycle immediately after reset -> m0 is granted first and m1 next; the following tie goes to m0 again (alternation). No master is granted twice while the other is waiting.
- Timeout: TIMEOUT=8, m0 reads device 5, which never acks -> s_stb_o[5] is high for 8 cycles, then m0_ack_o=m0_err_o=1 for one cycle and m0_dat_o=8'hff. A later m1 request is then serviced normally.
- Stray ack and mid-cycle change: device 3 acks while device 7 is selected -> ignored. Changing m0_adr_i during BUSY -> s_adr_o unchanged. Ack and timeout on the same edge -> err_o=0.
- Reset mid-operation: rst_i asserted in BUSY -> next cycle all strobes 0, all dat outputs 8'hff, no ack pulse; a fresh request is then granted to m0.
